c64_write_queue: RTL
====================

# c64_write_queue

Captures C64 cartridge-port writes to the `$DE00`–`$DE03` register window and turns them into queued, bank-qualified video-SRAM write requests. It sits directly upstream of the VGA scan-out/SRAM engine and replaces its single-entry, unqueued write latch. It runs entirely in the 100 MHz domain, with C64 bus signals synchronized internally. Writes are buffered in a small FIFO, so back-to-back 6510 stores are never lost while scan-out owns the SRAM.

## Interface

- `BASE_ADDR`, default 16'hDE00: base of the 4-byte register window.
- `FIFO_DEPTH`, default 4: number of queued write entries; must be a power of 2, ≥2.
- `SYNC_STAGES`, default 2: synchronizer depth for `i_64clk`.
- `clk100` in 1: 100 MHz system clock; all logic is on its rising edge.
- `rst` in 1: reset; asynchronous assert, active-low.
- `i_64clk` in 1: 6510 PHI2, asynchronous.
- `i_64rw` in 1: 1 = read, 0 = write.
- `i_64addr` in 16: C64 address bus.
- `i_64data` in 8: C64 data bus.
- `o_token` out 8: token register; bit0 = SRAM bank, bit6 = 320/640 mode, bit7 = screen on.
- `o_wr_valid` out 1: a queued write is available at the FIFO head.
- `i_wr_ready` in 1: consumer accepts the head entry this cycle.
- `o_wr_addr` out 17: {bank, addr[15:0]} of the head entry.
- `o_wr_data` out 8: data byte of the head entry.
- `o_full` out 1: FIFO full.
- `o_overflow` out 1: sticky flag; a push was dropped.
- `o_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation

- **PHI2 synchronizer.** `i_64clk` passes through `SYNC_STAGES` flops.
  - A falling edge is detected when the last stage is 0 and its previous value was 1.
  - This produces a single-cycle strobe `bus_stb`.
- **Bus delay line.** `i_64rw`, `i_64addr` and `i_64data` pass through a delay line of `SYNC_STAGES`+1 flops.
  - On `bus_stb`, the decoder uses the copy aligned to the last cycle in which synchronized PHI2 was high.
  - The bus value used is therefore one sampled before the real PHI2 fall.
- **Decode.** Decoding happens only on `bus_stb` with rw=0. Reads and out-of-window addresses are ignored. Offsets:
  - +0: `token` ← data. This write also clears `o_overflow`.
  - +1: `addr[7:0]` ← data.
  - +2: `addr[15:8]` ← data.
  - +3: push {`token[0]`, `addr`, data}.
- **Push rules.**
  - Bank is taken from `token` at push time, not at pop time.
  - If the FIFO is full and no pop occurs that cycle, the push is dropped and `o_overflow` ← 1.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted and `o_level` is unchanged.
- **Pop.** A pop happens when `o_wr_valid` & `i_wr_ready`. `i_wr_ready` while empty has no effect.
- **FIFO output.** The FIFO is show-ahead: `o_wr_*` always reflect the head entry and hold while `o_wr_valid`=1 & `i_wr_ready`=0.
- **Pointers.** Read and write pointers are $clog2(FIFO_DEPTH)+1 bits wide with wrap-bit full/empty detection.
- **Reset.** Every register and output resets to 0: `token`, `addr`, FIFO pointers, `o_wr_*`, `o_full`, `o_overflow`, `o_level`.
  - Reset mid-operation discards all queued entries.
  - The delay line also resets, so no false `bus_stb` fires on release.

## Timing

- Raw PHI2 fall to `bus_stb`: `SYNC_STAGES`+1 clk100 cycles.
- `bus_stb` to register update or FIFO push: 1 cycle.
- Push to `o_wr_valid`=1 (from empty): 1 cycle.
- Pop to next head visible: 1 cycle. Sustained throughput is 1 entry per cycle.
- At most one decode per PHI2 period (~100 clk100 cycles), so a consumer draining ≥1 entry per PHI2 period never overflows.
- `o_full`, `o_level` and `o_overflow` are registered and update the cycle after the push or pop.

## Configuration

- `C64WQ_AUTOINC_EN` defined:
  - Every accepted push increments `addr` by 1, wrapping $FFFF→$0000.
  - Bank is unchanged on wrap.
  - A dropped push does not increment.
- Not defined: `addr` changes only on writes to +1/+2.

## Structure

- Package `vg64_pkg` holds:
  - register offsets `REG_TOKEN`, `REG_LSB`, `REG_MSB`, `REG_OPERAND`;
  - token bit indices `TOK_BANK`, `TOK_HIRES`, `TOK_SCREEN`;
  - a write-request struct {bank, addr, data}.
- Sub-module `vg64_sync_fifo` is a parameterized show-ahead FIFO with level output.
- Top level contains the synchronizer, delay line, decoder, registers and overflow logic.

## Test plan

- **Address setup and single write.** Write $34→$DE01, $12→$DE02, $AB→$DE03 with token=$01 → one entry, `o_wr_addr`=17'h11234, `o_wr_data`=$AB, `o_level`=1.
- **Auto-increment across wrap** (`C64WQ_AUTOINC_EN`). Set addr $FFFF, then write $DE03 three times with `i_wr_ready`=0 → addresses $FFFF, $0000, $0001, all in bank 0.
- **Overflow.** Hold `i_wr_ready`=0 and write $DE03 5 times with `FIFO_DEPTH`=4 → `o_full`=1, `o_overflow`=1, `o_level`=4, 5th byte absent. Then a token write clears `o_overflow`.
- **Filtering.** Reads at $DE03 and writes to $DE04/$DDFF → no push, registers unchanged.
- **Simultaneous push/pop when full.** Full FIFO, `i_wr_ready`=1 in the push cycle → push accepted, `o_level` stays 4, `o_overflow`=0.
- **Reset mid-operation.** Assert `rst`=0 with 3 entries queued → next cycle `o_wr_valid`=0, `o_level`=0, `o_token`=0.

Source files
------------

// File: rtl/vg64_pkg.sv
// vg64_pkg: shared register offsets, token bit positions and bus payload types
// for the C64 cartridge-port write queue.
package vg64_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    // Register offsets inside the 4-byte window
    localparam logic [1:0] REG_TOKEN   = 2'd0;
    localparam logic [1:0] REG_LSB     = 2'd1;
    localparam logic [1:0] REG_MSB     = 2'd2;
    localparam logic [1:0] REG_OPERAND = 2'd3;

    // Token register bit positions
    localparam int unsigned TOK_BANK   = 0;
    localparam int unsigned TOK_HIRES  = 6;
    localparam int unsigned TOK_SCREEN = 7;

    // Queued video-SRAM write request
    typedef struct packed {
        logic              bank;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // One sample of the C64 bus
    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } bus_t;

endpackage

// File: rtl/vg64_sync_fifo.sv
// vg64_sync_fifo: show-ahead FIFO with wrap-bit pointers and registered
// valid/full/level. A push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module vg64_sync_fifo
    import vg64_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  wr_req_t                  i_data,
    input  logic                     i_ready,
    output logic                     o_push_ok_c,
    output logic                     o_valid,
    output wr_req_t                  o_head,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          valid_q, valid_d;
    logic          full_q, full_d;
    wr_req_t       mem_q [DEPTH];
    wr_req_t       mem_d [DEPTH];
    logic          pop;

    // Next-state: handshake, storage write, pointer and status update
    always_comb begin
        mem_d       = mem_q;
        pop         = valid_q & i_ready;
        o_push_ok_c = i_push & (~full_q | pop);
        if (o_push_ok_c) begin
            mem_d[wr_ptr_q[PW-1:0]] = i_data;
        end
        wr_ptr_d = wr_ptr_q + LW'(o_push_ok_c);
        rd_ptr_d = rd_ptr_q + LW'(pop);
        level_d  = wr_ptr_d - rd_ptr_d;
        valid_d  = (wr_ptr_d != rd_ptr_d);
        full_d   = (wr_ptr_d[PW] != rd_ptr_d[PW]) &&
                   (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            mem_q    <= mem_d;
        end
    end

    assign o_valid = valid_q;
    assign o_full  = full_q;
    assign o_level = level_q;
    assign o_head  = mem_q[rd_ptr_q[PW-1:0]];

endmodule

// File: rtl/c64_write_queue.sv
// c64_write_queue: decodes C64 writes to the BASE_ADDR..+3 window and queues
// bank-qualified video-SRAM write requests. Define C64WQ_AUTOINC_EN to make
// every accepted push post-increment the address register.
module c64_write_queue
    import vg64_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hDE00,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk100,
    input  logic                          rst,
    input  logic                          i_64clk,
    input  logic                          i_64rw,
    input  logic [15:0]                   i_64addr,
    input  logic [7:0]                    i_64data,
    output logic [7:0]                    o_token,
    output logic                          o_wr_valid,
    input  logic                          i_wr_ready,
    output logic [16:0]                   o_wr_addr,
    output logic [7:0]                    o_wr_data,
    output logic                          o_full,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   phi_prev_q, phi_prev_d;
    bus_t                   dl_q [SYNC_STAGES+1];
    bus_t                   dl_d [SYNC_STAGES+1];
    logic [7:0]             token_q, token_d;
    logic [15:0]            addr_q, addr_d;
    logic                   ovf_q, ovf_d;

    bus_t                   bus;
    logic                   bus_stb;
    logic [15:0]            offset;
    logic                   wr_hit;
    logic                   push;
    logic                   push_ok;
    wr_req_t                push_req;
    wr_req_t                head;

    // PHI2 synchronizer and bus delay line shift
    always_comb begin
        sync_d[0] = i_64clk;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
        phi_prev_d = sync_q[SYNC_STAGES-1];
        dl_d[0]    = {i_64rw, i_64addr, i_64data};
        for (int i = 1; i <= int'(SYNC_STAGES); i++) begin
            dl_d[i] = dl_q[i-1];
        end
    end

    // The oldest delay-line copy was sampled alongside the last high PHI2 sample
    assign bus     = dl_q[SYNC_STAGES];
    assign bus_stb = phi_prev_q & ~sync_q[SYNC_STAGES-1];
    assign offset  = bus.addr - BASE_ADDR;
    assign wr_hit  = bus_stb & ~bus.rw & (offset[15:2] == 14'd0);
    assign push    = wr_hit & (offset[1:0] == REG_OPERAND);

    // Register decode, overflow tracking and optional address post-increment
    always_comb begin
        token_d  = token_q;
        addr_d   = addr_q;
        ovf_d    = ovf_q;
        push_req = '{bank: token_q[TOK_BANK], addr: addr_q, data: bus.data};
        if (wr_hit) begin
            case (offset[1:0])
                REG_TOKEN: begin
                    token_d = bus.data;
                    ovf_d   = 1'b0;
                end
                REG_LSB:  addr_d[7:0]  = bus.data;
                REG_MSB:  addr_d[15:8] = bus.data;
                default:  ;
            endcase
        end
        if (push && !push_ok) begin
            ovf_d = 1'b1;
        end
`ifdef C64WQ_AUTOINC_EN
        if (push_ok) begin
            addr_d = addr_q + 16'd1;
        end
`endif
    end

    // State registers
    always_ff @(posedge clk100 or negedge rst) begin
        if (!rst) begin
            sync_q     <= '0;
            phi_prev_q <= 1'b0;
            for (int i = 0; i <= int'(SYNC_STAGES); i++) begin
                dl_q[i] <= '0;
            end
            token_q    <= '0;
            addr_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            phi_prev_q <= phi_prev_d;
            dl_q       <= dl_d;
            token_q    <= token_d;
            addr_q     <= addr_d;
            ovf_q      <= ovf_d;
        end
    end

    vg64_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk100),
        .rst_n       (rst),
        .i_push      (push),
        .i_data      (push_req),
        .i_ready     (i_wr_ready),
        .o_push_ok_c (push_ok),
        .o_valid     (o_wr_valid),
        .o_head      (head),
        .o_full      (o_full),
        .o_level     (o_level)
    );

    assign o_token    = token_q;
    assign o_overflow = ovf_q;
    assign o_wr_addr  = {head.bank, head.addr};
    assign o_wr_data  = head.data;

endmodule
